// File: rtl/sram_port_arbiter.sv
// Arbitrates one single-ported, one-cycle-latency SRAM between the fetch and data ports.
// Optional fetch starvation guard enabled by defining SRAM_ARB_STARVE_GUARD_EN.
module sram_port_arbiter #(
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        inst_req,
    input  logic [31:0] inst_addr,
    output logic        inst_addr_ok,
    output logic        inst_data_ok,
    output logic [31:0] inst_rdata,
    input  logic        data_req,
    input  logic        data_wr,
    input  logic [3:0]  data_wstrb,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_wdata,
    output logic        data_addr_ok,
    output logic        data_data_ok,
    output logic [31:0] data_rdata,
    output logic        sram_en,
    output logic [3:0]  sram_we,
    output logic [31:0] sram_addr,
    output logic [31:0] sram_wdata,
    input  logic [31:0] sram_rdata
);

    logic grant_inst;
    logic grant_data;
    logic force_inst;
    logic rsp_valid;
    logic rsp_owner;
    logic rsp_is_store;

`ifdef SRAM_ARB_STARVE_GUARD_EN
    localparam int unsigned CNT_W = 4;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [CNT_W-1:0] starve_cnt;
    logic [CNT_W-1:0] starve_cnt_nxt;

    // Fetch is forced through once it has watched STARVE_LIMIT data grants in a row.
    assign force_inst = inst_req && data_req && (starve_cnt == CNT_W'(STARVE_LIMIT));

    always_comb begin
        starve_cnt_nxt = starve_cnt;
        if (!inst_req || grant_inst) begin
            starve_cnt_nxt = '0;
        end else if (grant_data && (starve_cnt != CNT_MAX)) begin
            starve_cnt_nxt = starve_cnt + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            starve_cnt <= '0;
        end else begin
            starve_cnt <= starve_cnt_nxt;
        end
    end
`else
    logic unused_limit;
    assign unused_limit = ^32'(STARVE_LIMIT);
    assign force_inst   = 1'b0;
`endif

    // Data wins by default since it belongs to the older instruction.
    always_comb begin
        grant_data = resetn && data_req && !force_inst;
        grant_inst = resetn && inst_req && !grant_data;
    end

    always_comb begin
        sram_en    = 1'b0;
        sram_we    = 4'h0;
        sram_addr  = 32'h0;
        sram_wdata = 32'h0;
        if (grant_data) begin
            sram_en    = 1'b1;
            sram_we    = data_wr ? data_wstrb : 4'h0;
            sram_addr  = data_addr;
            sram_wdata = data_wr ? data_wdata : 32'h0;
        end else if (grant_inst) begin
            sram_en    = 1'b1;
            sram_addr  = inst_addr;
        end
    end

    // Response tracking: one entry, reloaded on every grant, cleared otherwise.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rsp_valid    <= 1'b0;
            rsp_owner    <= 1'b0;
            rsp_is_store <= 1'b0;
        end else begin
            rsp_valid    <= grant_inst || grant_data;
            rsp_owner    <= grant_data;
            rsp_is_store <= grant_data && data_wr;
        end
    end

    assign inst_addr_ok = grant_inst;
    assign data_addr_ok = grant_data;
    assign inst_data_ok = rsp_valid && !rsp_owner;
    assign data_data_ok = rsp_valid && rsp_owner;
    assign inst_rdata   = inst_data_ok ? sram_rdata : 32'h0;
    assign data_rdata   = (data_data_ok && !rsp_is_store) ? sram_rdata : 32'h0;

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Self-checking bench for sram_port_arbiter: vector table, directed corner sequences,
// and randomized traffic against a behavioural model with a shadow memory.
module tb_sram_port_arbiter;

    localparam int unsigned STARVE_LIMIT = 4;

    logic        clk = 1'b0;
    logic        resetn;
    logic        inst_req;
    logic [31:0] inst_addr;
    logic        inst_addr_ok;
    logic        inst_data_ok;
    logic [31:0] inst_rdata;
    logic        data_req;
    logic        data_wr;
    logic [3:0]  data_wstrb;
    logic [31:0] data_addr;
    logic [31:0] data_wdata;
    logic        data_addr_ok;
    logic        data_data_ok;
    logic [31:0] data_rdata;
    logic        sram_en;
    logic [3:0]  sram_we;
    logic [31:0] sram_addr;
    logic [31:0] sram_wdata;
    logic [31:0] sram_rdata;

    int n_pass  = 0;
    int n_total = 0;

    sram_port_arbiter #(.STARVE_LIMIT(STARVE_LIMIT)) dut (
        .clk          (clk),
        .resetn       (resetn),
        .inst_req     (inst_req),
        .inst_addr    (inst_addr),
        .inst_addr_ok (inst_addr_ok),
        .inst_data_ok (inst_data_ok),
        .inst_rdata   (inst_rdata),
        .data_req     (data_req),
        .data_wr      (data_wr),
        .data_wstrb   (data_wstrb),
        .data_addr    (data_addr),
        .data_wdata   (data_wdata),
        .data_addr_ok (data_addr_ok),
        .data_data_ok (data_data_ok),
        .data_rdata   (data_rdata),
        .sram_en      (sram_en),
        .sram_we      (sram_we),
        .sram_addr    (sram_addr),
        .sram_wdata   (sram_wdata),
        .sram_rdata   (sram_rdata)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] pat(input int i);
        return (32'(i) * 32'h0101_0101) ^ 32'hA5A5_0000;
    endfunction

    // SRAM environment: one-cycle read latency, byte writes, reloaded while in reset.
    logic [31:0] mem [256];
    always @(posedge clk) begin
        if (!resetn) begin
            for (int i = 0; i < 256; i++) mem[i] <= pat(i);
        end else if (sram_en) begin
            sram_rdata <= mem[sram_addr[9:2]];
            for (int b = 0; b < 4; b++)
                if (sram_we[b]) mem[sram_addr[9:2]][8*b +: 8] <= sram_wdata[8*b +: 8];
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    endtask

    task automatic idle_inputs();
        inst_req   = 1'b0;
        inst_addr  = 32'h0;
        data_req   = 1'b0;
        data_wr    = 1'b0;
        data_wstrb = 4'h0;
        data_addr  = 32'h0;
        data_wdata = 32'h0;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic data_access(input logic wr, input logic [3:0] strb,
                               input logic [31:0] addr, input logic [31:0] wdata);
        data_req   = 1'b1;
        data_wr    = wr;
        data_wstrb = strb;
        data_addr  = addr;
        data_wdata = wdata;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, ".inst_addr_ok"}, inst_addr_ok, 0);
        check({tag, ".data_addr_ok"}, data_addr_ok, 0);
        check({tag, ".inst_data_ok"}, inst_data_ok, 0);
        check({tag, ".data_data_ok"}, data_data_ok, 0);
        check({tag, ".inst_rdata"},   inst_rdata,   0);
        check({tag, ".data_rdata"},   data_rdata,   0);
        check({tag, ".sram_en"},      sram_en,      0);
        check({tag, ".sram_we"},      sram_we,      0);
        check({tag, ".sram_addr"},    sram_addr,    0);
        check({tag, ".sram_wdata"},   sram_wdata,   0);
    endtask

    typedef struct {
        logic        ireq;
        logic [31:0] iaddr;
        logic        dreq;
        logic        dwr;
        logic [3:0]  wstrb;
        logic [31:0] daddr;
        logic [31:0] wdata;
        logic        e_iok;
        logic        e_dok;
        logic        e_en;
        logic [3:0]  e_we;
        logic [31:0] e_addr;
        logic [31:0] e_wdata;
    } vec_t;

    vec_t vecs[8];

    // Random-phase model state
    logic [31:0] ref_mem [256];
    int          streak;
    logic        ip, dp, dwr_r, gi, gd, frc;
    logic [31:0] ia, da, wd;
    logic [3:0]  ws;
    logic        exp_iok, exp_dok;
    logic [31:0] exp_ir, exp_dr;

    initial begin
        idle_inputs();
        resetn = 1'b0;
        // Requests present during reset must not be granted.
        inst_req = 1'b1;
        data_req = 1'b1;
        data_addr = 32'h40;
        inst_addr = 32'h1C00_0000;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_all_zero("reset");
        next_cycle();
        resetn = 1'b1;
        idle_inputs();

        vecs[0] = '{1'b0, 32'h0,          1'b0, 1'b0, 4'h0, 32'h0,   32'h0,
                    1'b0, 1'b0, 1'b0, 4'h0, 32'h0,          32'h0};
        vecs[1] = '{1'b1, 32'h1C00_0000,  1'b0, 1'b0, 4'h0, 32'h0,   32'h0,
                    1'b1, 1'b0, 1'b1, 4'h0, 32'h1C00_0000,  32'h0};
        vecs[2] = '{1'b0, 32'h0,          1'b1, 1'b0, 4'h0, 32'h100, 32'h0,
                    1'b0, 1'b1, 1'b1, 4'h0, 32'h100,        32'h0};
        vecs[3] = '{1'b0, 32'h0,          1'b1, 1'b1, 4'hF, 32'h104, 32'h1122_3344,
                    1'b0, 1'b1, 1'b1, 4'hF, 32'h104,        32'h1122_3344};
        vecs[4] = '{1'b1, 32'h1C00_0004,  1'b1, 1'b0, 4'h0, 32'h108, 32'h0,
                    1'b0, 1'b1, 1'b1, 4'h0, 32'h108,        32'h0};
        vecs[5] = '{1'b1, 32'h1C00_0004,  1'b0, 1'b0, 4'h0, 32'h0,   32'h0,
                    1'b1, 1'b0, 1'b1, 4'h0, 32'h1C00_0004,  32'h0};
        vecs[6] = '{1'b0, 32'h0,          1'b1, 1'b1, 4'h0, 32'h10C, 32'hAAAA_5555,
                    1'b0, 1'b1, 1'b1, 4'h0, 32'h10C,        32'hAAAA_5555};
        vecs[7] = '{1'b0, 32'h0,          1'b0, 1'b0, 4'h0, 32'h0,   32'h0,
                    1'b0, 1'b0, 1'b0, 4'h0, 32'h0,          32'h0};

        for (int i = 0; i < 8; i++) begin
            inst_req   = vecs[i].ireq;
            inst_addr  = vecs[i].iaddr;
            data_req   = vecs[i].dreq;
            data_wr    = vecs[i].dwr;
            data_wstrb = vecs[i].wstrb;
            data_addr  = vecs[i].daddr;
            data_wdata = vecs[i].wdata;
            @(negedge clk);
            check($sformatf("vec%0d.inst_addr_ok", i), inst_addr_ok, vecs[i].e_iok);
            check($sformatf("vec%0d.data_addr_ok", i), data_addr_ok, vecs[i].e_dok);
            check($sformatf("vec%0d.sram_en", i),      sram_en,      vecs[i].e_en);
            check($sformatf("vec%0d.sram_we", i),      sram_we,      vecs[i].e_we);
            check($sformatf("vec%0d.sram_addr", i),    sram_addr,    vecs[i].e_addr);
            check($sformatf("vec%0d.sram_wdata", i),   sram_wdata,   vecs[i].e_wdata);
            // Every vector before this one granted exactly one side (except idle ones).
            if (i > 0) begin
                check($sformatf("vec%0d.inst_data_ok", i), inst_data_ok, vecs[i-1].e_iok);
                check($sformatf("vec%0d.data_data_ok", i), data_data_ok, vecs[i-1].e_dok);
            end
            next_cycle();
        end
        idle_inputs();

        // Preload words used below through the arbiter itself.
        data_access(1'b1, 4'hF, 32'h0, 32'h0280_0C0C);
        next_cycle();
        data_access(1'b1, 4'hF, 32'h100, 32'h1234_5678);
        next_cycle();
        idle_inputs();
        next_cycle();

        // Lone fetch
        inst_req  = 1'b1;
        inst_addr = 32'h1C00_0000;
        @(negedge clk);
        check("fetch.addr_ok", inst_addr_ok, 1);
        check("fetch.sram_en", sram_en, 1);
        check("fetch.sram_we", sram_we, 0);
        next_cycle();
        idle_inputs();
        @(negedge clk);
        check("fetch.data_ok", inst_data_ok, 1);
        check("fetch.rdata", inst_rdata, 32'h0280_0C0C);
        check("fetch.no_data_ok", data_data_ok, 0);
        next_cycle();

        // Store then load back-to-back
        data_access(1'b1, 4'h3, 32'h100, 32'hDEAD_BEEF);
        @(negedge clk);
        check("st.addr_ok", data_addr_ok, 1);
        check("st.sram_we", sram_we, 4'h3);
        next_cycle();
        data_access(1'b0, 4'h0, 32'h100, 32'h0);
        @(negedge clk);
        check("ld.sram_we", sram_we, 4'h0);
        check("st.data_ok", data_data_ok, 1);
        check("st.rdata", data_rdata, 0);
        next_cycle();
        idle_inputs();
        @(negedge clk);
        check("ld.data_ok", data_data_ok, 1);
        check("ld.rdata", data_rdata, 32'h1234_BEEF);
        next_cycle();

        // Collision
        inst_req  = 1'b1;
        inst_addr = 32'h1C00_0008;
        data_access(1'b0, 4'h0, 32'h100, 32'h0);
        @(negedge clk);
        check("col.c0.data_addr_ok", data_addr_ok, 1);
        check("col.c0.inst_addr_ok", inst_addr_ok, 0);
        next_cycle();
        data_req = 1'b0;
        @(negedge clk);
        check("col.c1.inst_addr_ok", inst_addr_ok, 1);
        check("col.c1.data_addr_ok", data_addr_ok, 0);
        check("col.c1.data_data_ok", data_data_ok, 1);
        next_cycle();
        idle_inputs();
        @(negedge clk);
        check("col.c2.inst_data_ok", inst_data_ok, 1);
        check("col.c2.data_data_ok", data_data_ok, 0);
        next_cycle();

        // Starvation: both requests held continuously
        inst_req  = 1'b1;
        inst_addr = 32'h1C00_0000;
        data_access(1'b0, 4'h0, 32'h100, 32'h0);
        for (int i = 0; i < 15; i++) begin
            logic exp_inst;
`ifdef SRAM_ARB_STARVE_GUARD_EN
            exp_inst = ((i % (STARVE_LIMIT + 1)) == STARVE_LIMIT);
`else
            exp_inst = 1'b0;
`endif
            @(negedge clk);
            check($sformatf("starve.c%0d.inst_addr_ok", i), inst_addr_ok, exp_inst);
            check($sformatf("starve.c%0d.data_addr_ok", i), data_addr_ok, !exp_inst);
            check($sformatf("starve.c%0d.one_grant", i), inst_addr_ok & data_addr_ok, 0);
            next_cycle();
        end
        idle_inputs();
        next_cycle();

        // Reset in the middle of a load
        data_access(1'b0, 4'h0, 32'h100, 32'h0);
        @(negedge clk);
        check("rst.c0.data_addr_ok", data_addr_ok, 1);
        next_cycle();
        resetn   = 1'b0;
        inst_req = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check_all_zero($sformatf("rst.c%0d", i + 1));
            next_cycle();
        end
        resetn = 1'b1;
        idle_inputs();
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check($sformatf("rst.post%0d.data_data_ok", i), data_data_ok, 0);
            check($sformatf("rst.post%0d.inst_data_ok", i), inst_data_ok, 0);
            next_cycle();
        end

        // Idle
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check($sformatf("idle.c%0d.sram_en", i), sram_en, 0);
            check($sformatf("idle.c%0d.sram_addr", i), sram_addr, 0);
            check($sformatf("idle.c%0d.data_ok", i), inst_data_ok | data_data_ok, 0);
            next_cycle();
        end

        // Randomized traffic against the behavioural model
        resetn = 1'b0;
        idle_inputs();
        for (int i = 0; i < 256; i++) ref_mem[i] = pat(i);
        repeat (2) @(posedge clk);
        #1;
        resetn  = 1'b1;
        streak  = 0;
        ip      = 1'b0;
        dp      = 1'b0;
        exp_iok = 1'b0;
        exp_dok = 1'b0;
        exp_ir  = 32'h0;
        exp_dr  = 32'h0;
        ia = 32'h0; da = 32'h0; wd = 32'h0; ws = 4'h0; dwr_r = 1'b0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            if (!ip && ($urandom_range(0, 99) < 60)) begin
                ip = 1'b1;
                ia = 32'h1C00_0000 | (32'($urandom_range(0, 15)) << 2);
            end
            if (!dp && ($urandom_range(0, 99) < 60)) begin
                dp    = 1'b1;
                dwr_r = 1'($urandom_range(0, 1));
                ws    = 4'($urandom_range(0, 15));
                da    = 32'($urandom_range(0, 15)) << 2;
                wd    = $urandom;
            end
            inst_req   = ip;
            inst_addr  = ia;
            data_req   = dp;
            data_wr    = dwr_r;
            data_wstrb = ws;
            data_addr  = da;
            data_wdata = wd;

`ifdef SRAM_ARB_STARVE_GUARD_EN
            frc = ip && dp && (streak == STARVE_LIMIT);
`else
            frc = 1'b0;
`endif
            gd = dp && !frc;
            gi = ip && !gd;

            @(negedge clk);
            check("rnd.inst_addr_ok", inst_addr_ok, gi);
            check("rnd.data_addr_ok", data_addr_ok, gd);
            check("rnd.sram_en", sram_en, gi | gd);
            check("rnd.sram_we", sram_we, (gd && dwr_r) ? ws : 4'h0);
            check("rnd.sram_addr", sram_addr, gd ? da : (gi ? ia : 32'h0));
            if (gd && dwr_r) check("rnd.sram_wdata", sram_wdata, wd);
            check("rnd.inst_data_ok", inst_data_ok, exp_iok);
            check("rnd.data_data_ok", data_data_ok, exp_dok);
            check("rnd.inst_rdata", inst_rdata, exp_ir);
            check("rnd.data_rdata", data_rdata, exp_dr);

            exp_iok = gi;
            exp_dok = gd;
            exp_ir  = gi ? ref_mem[ia[9:2]] : 32'h0;
            exp_dr  = (gd && !dwr_r) ? ref_mem[da[9:2]] : 32'h0;
            if (gd && dwr_r)
                for (int b = 0; b < 4; b++)
                    if (ws[b]) ref_mem[da[9:2]][8*b +: 8] = wd[8*b +: 8];
            if (!ip || gi) streak = 0;
            else if (gd && streak < 15) streak++;
            if (gi) ip = 1'b0;
            if (gd) dp = 1'b0;
            next_cycle();
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/sram_port_arbiter.md
# sram_port_arbiter

Shares one single-ported, one-cycle-latency SRAM between the instruction-fetch port and the data-access port of the pipelined core. It sits between the IF/MEM stages and the unified memory in place of the split inst/data SRAM pair. Each requester sees a req / addr_ok / data_ok handshake, and the SRAM sees a plain en/we/addr/wdata port. The arbiter pipelines grants so that one access per cycle can be sustained, and data accesses are favoured over fetches.

## Interface
Parameters:
- STARVE_LIMIT, 4: consecutive data grants tolerated while a fetch waits. Legal range 1..15. Used only with the guard macro.

Ports:
- clk  in  1  clock; all state updates on the rising edge
- resetn  in  1  asynchronous, active-low reset
- inst_req  in  1  fetch request; held until addr_ok
- inst_addr  in  32  fetch byte address
- inst_addr_ok  out  1  fetch accepted this cycle (combinational)
- inst_data_ok  out  1  fetch data valid (registered)
- inst_rdata  out  32  fetch data; 0 when inst_data_ok=0
- data_req  in  1  load/store request; held until addr_ok
- data_wr  in  1  1=store, 0=load
- data_wstrb  in  4  store byte enables
- data_addr  in  32  data byte address
- data_wdata  in  32  store data
- data_addr_ok  out  1  data request accepted this cycle (combinational)
- data_data_ok  out  1  load data valid / store complete (registered)
- data_rdata  out  32  load data; 0 when data_data_ok=0 or on a store
- sram_en  out  1  SRAM access this cycle
- sram_we  out  4  SRAM byte write enables; 0 on reads
- sram_addr  out  32  SRAM address
- sram_wdata  out  32  SRAM write data
- sram_rdata  in  32  SRAM read data, valid the cycle after en

## Operation
- Grant is combinational each cycle and goes to at most one requester.
- A granted requester gets addr_ok=1 and its request is driven onto sram_* in the same cycle.
- Default priority: data beats inst, because the data access belongs to an older instruction.
- Response register: rsp_valid, rsp_owner (0=inst, 1=data), rsp_is_store.
  - Loaded on every grant.
  - Cleared on any cycle without a grant.
- When rsp_valid=1, the owner's data_ok=1 and the owner's rdata=sram_rdata.
  - For a store, data_ok=1 and data_rdata=0.
- A new grant may occur in the same cycle as a response, so back-to-back accesses run at one per cycle.
- With no grant: sram_en=0, sram_we=0, sram_addr=0, sram_wdata=0.
- On a load: sram_we=0.
- On a store: sram_we=data_wstrb. A store with wstrb=0 is still granted and still returns data_ok.
- Requesters must not drop req or change their request fields before addr_ok. The arbiter does not check this.

## Timing
- Reset values: all registers 0. addr_ok, data_ok, rdata and sram_* all read 0.
- While resetn=0, combinational grant is forced off.
- Reset asserted mid-transaction: the pending response is discarded and no data_ok is issued after reset deasserts.
- Latency:
  - addr_ok occurs in cycle T, the cycle req is sampled high and wins.
  - data_ok occurs in cycle T+1, exactly once per accepted request.
- Sustained throughput is 1 access/cycle. The losing requester waits, with its req held, until it wins.
- Simultaneous inst_req and data_req: data wins unless the starvation guard forces inst (see Configuration).

## Configuration
- Macro: SRAM_ARB_STARVE_GUARD_EN.
- Defined: a saturating counter (4 bits) tracks waiting fetches.
  - It increments on each cycle where data is granted while inst_req=1.
  - It clears on an inst grant and on any cycle with inst_req=0.
  - When the counter equals STARVE_LIMIT and both requests are present, inst wins and the counter clears.
- Undefined: strict data priority with no counter. Continuous data requests may starve fetch indefinitely.

## Test plan
- Lone fetch:
  - Stimulus: inst_req=1, inst_addr=0x1C000000; SRAM returns 0x02800C0C.
  - Required: inst_addr_ok and sram_en=1 in cycle 0 with sram_we=0; in cycle 1, inst_data_ok=1 and inst_rdata=0x02800C0C.
- Store then load back-to-back:
  - Stimulus: store to 0x100 with wstrb=0x3, wdata=0xDEADBEEF; next cycle, load from 0x100.
  - Required: sram_we=0x3 in cycle 0, then 0x0 in cycle 1; data_data_ok in cycles 1 and 2; data_rdata=0 in cycle 1 and =SRAM value in cycle 2.
- Collision:
  - Stimulus: inst_req and data_req both high in cycle 0.
  - Required: data_addr_ok in cycle 0; inst_addr_ok in cycle 1; data_data_ok in cycle 1; inst_data_ok in cycle 2; never two addr_ok in one cycle.
- Starvation, guard defined, STARVE_LIMIT=4:
  - Stimulus: both reqs held high continuously.
  - Required: data is granted in cycles 0-3, inst in cycle 4, and the pattern repeats.
  - With the guard undefined, inst is never granted.
- Reset mid-op:
  - Stimulus: load granted in cycle 0; resetn=0 in cycle 1 for 2 cycles.
  - Required: no data_data_ok during or after reset; all outputs 0 during reset.
- Idle:
  - Stimulus: no requests for 10 cycles.
  - Required: sram_en=0 and sram_addr=0 throughout; no data_ok.
